count_seq_checker: RTL and testbench
====================================

// Module: count_seq_checker
// PURPOSE
//  Downstream monitor for the 4-bit synchronous up counter. Samples the counter value
//  and checks that it advances by exactly +1 mod 2^WIDTH on each sample. Counts
//  wrap-arounds (max->0), flags illegal jumps and stalls, and tracks lock state.
//  Sits on the counter's output bus and feeds status/debug logic.
// PARAMETERS
//  WIDTH      4   width of monitored count
//  WRAP_W     8   width of wrap_count (saturating)
//  STALL_MAX  16  consecutive repeated samples before stall_err; must be >= 2
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous reset, active-high
//  count_in    in   WIDTH    counter value under check
//  sample_en   in   1        count_in is valid this cycle
//  err_clr     in   1        clear sticky error flags
//  locked      out  1        checker tracking a valid sequence (TRACK state)
//  wrap_pulse  out  1        one-cycle pulse per legal wrap max->0
//  wrap_count  out  WRAP_W   legal wraps seen while locked, saturates at all-ones
//  seq_err     out  1        sticky: illegal jump seen
//  stall_err   out  1        sticky: count held STALL_MAX samples
// BEHAVIOUR
//  - rst=1 (async): state=UNLOCKED, prev=0, good_cnt=0, stall_cnt=0, all outputs 0.
//  - Registered outputs, updated on the clk edge that samples count_in (latency 1).
//  - Only cycles with sample_en=1 are evaluated. sample_en=0: all state held,
//    wrap_pulse=0.
//  - Evaluation per sample, nxt = prev+1 mod 2^WIDTH:
//    GOOD  count_in==nxt; STALL count_in==prev; BAD otherwise.
//  - FSM:
//    UNLOCKED: prev<=count_in -> RESYNC, good_cnt=0.
//    RESYNC: GOOD -> good_cnt++, and at 2 consecutive GOODs -> TRACK.
//      BAD -> good_cnt=0, stay RESYNC. STALL -> good_cnt kept.
//      No wrap counting and no seq_err in RESYNC.
//    TRACK: GOOD -> stay TRACK. If prev==2^WIDTH-1 (count_in==0), wrap_pulse=1
//      next cycle and wrap_count++ unless saturated.
//      STALL -> stay TRACK. BAD -> seq_err=1, locked=0, -> RESYNC, good_cnt=0.
//  - prev<=count_in on every evaluated sample in every state.
//  - locked=1 exactly while in TRACK.
//  - stall_cnt (all states except UNLOCKED):
//    STALL -> stall_cnt++ (saturating). GOOD/BAD -> stall_cnt=0.
//    stall_err=1 when stall_cnt reaches STALL_MAX-1 on a STALL sample, i.e. the
//    STALL_MAX-th consecutive equal sample. A stall does not drop lock.
//  - err_clr=1 clears seq_err and stall_err. A set in the same cycle wins (flag
//    stays 1). Counters and FSM state are not affected.
//  - Drop to 0 from a non-max value is BAD (counter reset mid-run):
//    seq_err in TRACK, resync follows.
//  - rst asserted mid-operation: immediate return to reset values.
//    wrap_count is lost.
// TESTING
//  1. Reset, then 0,1,...,15,0,1 with sample_en=1 every cycle -> locked=1 after
//     3rd sample; one wrap_pulse on sample 0 after 15; wrap_count=1; no errors.
//  2. Locked at 5, inject 9 -> seq_err=1 and locked=0 next cycle; 10,11 -> locked=1 again.
//     err_clr -> seq_err=0.
//  3. Locked, hold count_in=7 for 16 samples -> stall_err=1 after the 16th.
//     Locked remains 1, and 15 samples do not set it.
//  4. WRAP_W=2: 5 full wraps -> wrap_count saturates at 3; wrap_pulse still fires 5 times.
//  5. sample_en toggling 1/0 with gaps over 14,15,0 -> gaps ignored, single wrap counted.
//     err_clr coincident with BAD -> seq_err stays 1.
//  6. Assert rst mid-run (wrap_count=2, seq_err=1) -> all outputs 0 asynchronously.
//     After release, relock requires 3 samples.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a free-running up counter for +1 steps, wraps, jumps and stalls
module count_seq_checker #(
  parameter int WIDTH = 4,
  parameter int WRAP_W = 8,
  parameter int STALL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              sample_en,
  input  logic              err_clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err,
  output logic              stall_err
);
  localparam int SW = $clog2(STALL_MAX);
  localparam logic [SW-1:0] S_SAT = SW'(STALL_MAX - 1);
  localparam logic [SW-1:0] S_THR = SW'(STALL_MAX - 2);
  typedef enum logic [1:0] {UNLOCKED, RESYNC, TRACK} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] prev, nxt;
  logic [1:0] good_cnt, good_cnt_n;
  logic [SW-1:0] stall_cnt, stall_cnt_n;
  logic [WRAP_W-1:0] wrap_count_n;
  logic good, stall, wrap_pulse_n, seq_set, stall_set;
  assign locked = state == TRACK;
  always_comb begin
    nxt = prev + 1'b1;
    good = count_in == nxt;
    stall = count_in == prev;
    state_n = state;
    good_cnt_n = good_cnt;
    stall_cnt_n = stall_cnt;
    wrap_pulse_n = 1'b0;
    wrap_count_n = wrap_count;
    seq_set = 1'b0;
    stall_set = 1'b0;
    if (sample_en) begin
      case (state)
        UNLOCKED: begin
          state_n = RESYNC;
          good_cnt_n = '0;
        end
        RESYNC: begin
          good_cnt_n = good ? good_cnt + 2'd1 : (stall ? good_cnt : '0);
          state_n = (good && good_cnt == 2'd1) ? TRACK : RESYNC;
        end
        default: begin
          wrap_pulse_n = good && (&prev);
          wrap_count_n = (wrap_pulse_n && !(&wrap_count)) ? wrap_count + 1'b1 : wrap_count;
          seq_set = !good && !stall;
          state_n = seq_set ? RESYNC : TRACK;
          good_cnt_n = seq_set ? '0 : good_cnt;
        end
      endcase
      // a stall only counts once a reference sample exists
      if (state != UNLOCKED) begin
        stall_cnt_n = stall ? (stall_cnt == S_SAT ? stall_cnt : stall_cnt + 1'b1) : '0;
        stall_set = stall && stall_cnt >= S_THR;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNLOCKED;
      prev <= '0;
      good_cnt <= '0;
      stall_cnt <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      seq_err <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      if (sample_en) prev <= count_in;
      state <= state_n;
      good_cnt <= good_cnt_n;
      stall_cnt <= stall_cnt_n;
      wrap_pulse <= wrap_pulse_n;
      wrap_count <= wrap_count_n;
      seq_err <= seq_set | (seq_err & ~err_clr);
      stall_err <= stall_set | (stall_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed checks of the counter sequence monitor
module tb_count_seq_checker;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, err_clr = 1'b0;
  logic [3:0] count_in = '0;
  logic locked, wrap_pulse, seq_err, stall_err;
  logic [7:0] wrap_count;
  logic w2_locked, w2_pulse, w2_seq, w2_stall;
  logic [1:0] w2_count;
  int checks = 0, passed = 0, pulses = 0;
  always #5 clk = ~clk;
  count_seq_checker u_dut (
    .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .err_clr(err_clr),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .seq_err(seq_err), .stall_err(stall_err)
  );
  count_seq_checker #(.WRAP_W(2)) u_w2 (
    .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en), .err_clr(err_clr),
    .locked(w2_locked), .wrap_pulse(w2_pulse), .wrap_count(w2_count),
    .seq_err(w2_seq), .stall_err(w2_stall)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else passed++;
  endtask
  task automatic smp(input logic [3:0] v);
    count_in = v;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask
  task automatic idle();
    sample_en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_wrap", {wrap_pulse, wrap_count}, 0);
    chk("rst_errs", {seq_err, stall_err}, 0);
    rst = 1'b0;
    // straight run 0..15,0,1
    smp(0);
    smp(1);
    chk("t1_locked_2", locked, 0);
    smp(2);
    chk("t1_locked_3", locked, 1);
    for (int i = 3; i < 16; i++) smp(4'(i));
    chk("t1_no_pulse", wrap_pulse, 0);
    smp(0);
    chk("t1_pulse", wrap_pulse, 1);
    chk("t1_wrap_cnt", wrap_count, 1);
    smp(1);
    chk("t1_pulse_once", wrap_pulse, 0);
    chk("t1_no_err", {seq_err, stall_err}, 0);
    // illegal jump then relock
    for (int i = 2; i < 6; i++) smp(4'(i));
    smp(9);
    chk("t2_seq_err", seq_err, 1);
    chk("t2_unlock", locked, 0);
    smp(10);
    chk("t2_resync", locked, 0);
    smp(11);
    chk("t2_relock", locked, 1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("t2_clr", seq_err, 0);
    // stall hold at 7
    for (int i = 12; i < 23; i++) smp(4'(i));
    chk("t3_wrap_cnt", wrap_count, 2);
    for (int i = 0; i < 15; i++) smp(7);
    chk("t3_stall_15", stall_err, 0);
    smp(7);
    chk("t3_stall_16", stall_err, 1);
    chk("t3_still_locked", locked, 1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("t3_clr", stall_err, 0);
    // gaps across the wrap
    for (int i = 8; i < 15; i++) smp(4'(i));
    idle();
    idle();
    smp(15);
    idle();
    chk("t5_gap_locked", locked, 1);
    smp(0);
    chk("t5_pulse", wrap_pulse, 1);
    idle();
    chk("t5_pulse_end", wrap_pulse, 0);
    chk("t5_wrap_cnt", wrap_count, 3);
    chk("t5_no_seq", seq_err, 0);
    err_clr = 1'b1;
    smp(5);
    err_clr = 1'b0;
    chk("t5_set_wins", seq_err, 1);
    chk("t5_unlock", locked, 0);
    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("t6_async_rst", {locked, wrap_pulse, wrap_count, seq_err, stall_err}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // relock then five wraps into a 2-bit saturating counter
    smp(0);
    smp(1);
    chk("t6_relock_2", locked, 0);
    smp(2);
    chk("t6_relock_3", locked, 1);
    for (int k = 0; k < 5; k++)
      for (int i = (k == 0) ? 3 : 0; i < 16; i++) begin
        smp(4'(i));
        if (w2_pulse) pulses++;
      end
    smp(0);
    if (w2_pulse) pulses++;
    chk("t4_pulses", pulses, 5);
    chk("t4_sat", w2_count, 3);
    chk("t4_wide_cnt", wrap_count, 5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
